arb_rr_4: RTL
=============

// Module: arb_rr_4
// PURPOSE
//  Four-requester arbiter sharing one downstream resource. Winner selection uses a
//  4:2 priority coder on a rotated request vector. Mode is fixed priority (req[3]
//  highest) or round-robin. A grant is held until its requester releases or a hold
//  timeout expires. Sits between the requesting masters and the shared resource mux.
// PARAMETERS
//  ROUND_ROBIN  1  1: last winner becomes lowest priority; 0: fixed order 3>2>1>0
//  MAX_HOLD     8  max consecutive grant cycles (>=1); 0 = unlimited hold
// PORTS
//  clk      in   1  single clock, rising edge
//  rst      in   1  synchronous, active-high reset
//  req      in   4  level request per requester, index 3..0
//  gnt      out  4  one-hot grant (registered); 4'b0000 when none
//  gnt_id   out  2  binary index of gnt; 2'b00 when gnt==0
//  busy     out  1  1 while a grant is active (== |gnt)
//  expire   out  1  1-cycle pulse: grant ended by timeout, requester still requesting
// BEHAVIOUR
//  Reset (sync): state=IDLE, gnt=0, gnt_id=0, busy=0, expire=0, ptr=0, hold_cnt=0.
//   Reset asserted mid-grant clears everything at that edge; no expire pulse.
//  State IDLE: rotated vector r[k]=req[(ptr+k)%4], k=0..3; the coder returns Y and W (any).
//   If W: winner=(ptr+Y)%4 (2-bit wrap), gnt<=1<<winner, gnt_id<=winner, busy<=1,
//   hold_cnt<=0, go GRANT. If !W: stay IDLE, outputs 0.
//   Priority order is therefore ptr-1, ptr-2, ptr-3, ptr (mod 4). At ptr=0 this is 3,2,1,0.
//  Latency: req sampled in IDLE cycle t -> gnt visible from cycle t+1.
//  State GRANT: hold_cnt increments each cycle. Release condition:
//   (a) req[gnt_id]==0, or (b) MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1.
//   The grant lasts at most MAX_HOLD cycles.
//   On release edge: gnt<=0, gnt_id<=0, busy<=0, go IDLE.
//   ptr<=gnt_id if ROUND_ROBIN, else ptr stays 0.
//   expire<=1 only for (b) with req[gnt_id] still 1. If (a) and (b) occur together,
//   the release is treated as (a) and expire=0.
//  Minimum one dead cycle (gnt=0) between consecutive grants, for resource turnaround.
//  Changes on non-granted req bits during GRANT are ignored. No preemption.
//  Widths: hold_cnt width CW=$clog2(MAX_HOLD+1) (min 1); ptr 2 bits, wraps naturally.
//  expire is 0 in every cycle except the one following a timeout release.
// STRUCTURE
//  arb_defs.vh (shared include): state encodings ST_IDLE=1'b0, ST_GRANT=1'b1; N_REQ=4.
//  Sub-module pc_4_2: combinational 4:2 priority coder (I[3:0] -> Y[1:0], W). Highest
//   set bit wins; Y=0,W=0 for all-zero input. Instantiated once on r.
//  Top: rotate logic, FSM, hold counter, ptr register, output registers.
// TESTING
//  1 rst, then req=4'b0101 held -> next cycle gnt=4'b0100, gnt_id=2, busy=1.
//  2 ROUND_ROBIN=1, MAX_HOLD=4, req=4'b1111 held -> gnt 1000 x4 cycles, expire
//    pulse, gap, 0100 x4, gap, 0010 x4, gap, 0001 x4, gap, 1000 ...
//  3 ROUND_ROBIN=0, same stimulus -> gnt=1000 x4, expire, 1-cycle gap, 1000 again
//    indefinitely.
//  4 RR: grant to 2, drop req[2] -> gnt=0 next edge, expire=0, ptr=2. Then
//    req=4'b1011 -> gnt=4'b0010 (order 1,0,3,2).
//  5 req=0000 for 10 cycles -> gnt=0, busy=0, expire=0 throughout. MAX_HOLD=4:
//    req[gnt_id] drops on 4th grant cycle -> release, expire=0.
//  6 rst pulsed during a grant with ptr=3 -> gnt=0 at that edge, no expire.
//    Then req=4'b0011 -> gnt=4'b0010 (ptr back to 0).

Source files
------------

// File: rtl/arb_rr_4_pkg.sv
// arb_rr_4_pkg: shared state encoding, requester count and rotate helper for the arbiter
package arb_rr_4_pkg;
  localparam int N_REQ = 4;
  typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;
  function automatic logic [N_REQ-1:0] rot(input logic [N_REQ-1:0] v, input logic [1:0] p);
    logic [2*N_REQ-1:0] d;
    d = {v, v} >> p;
    return d[N_REQ-1:0];
  endfunction
endpackage

// File: rtl/arb_rr_4_pc_4_2.sv
// pc_4_2: combinational 4:2 priority coder, highest set bit wins, zero input gives Y=0 W=0
module pc_4_2
  import arb_rr_4_pkg::*;
(
  input  logic [N_REQ-1:0] I,
  output logic [1:0]       Y,
  output logic             W
);
  // encode the index of the highest set bit
  always_comb begin
    Y = I[3] ? 2'd3 : I[2] ? 2'd2 : I[1] ? 2'd1 : 2'd0;
    W = |I;
  end
endmodule

// File: rtl/arb_rr_4.sv
// arb_rr_4: four-requester arbiter with rotating priority, hold timeout and registered one-hot grant
module arb_rr_4
  import arb_rr_4_pkg::*;
#(
  parameter int ROUND_ROBIN = 1,
  parameter int MAX_HOLD    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [1:0]       gnt_id,
  output logic             busy,
  output logic             expire
);
  localparam int CW = MAX_HOLD > 0 ? $clog2(MAX_HOLD + 1) : 1;
  state_t          r_state;
  logic [1:0]      r_ptr;
  logic [CW-1:0]   r_hold;
  logic [N_REQ-1:0] w_rot;
  logic [1:0]      w_y;
  logic            w_w;
  logic [1:0]      w_win;
  logic            w_rel_a;
  logic            w_rel_b;
  assign w_rot   = rot(req, r_ptr);
  assign w_win   = r_ptr + w_y;
  assign w_rel_a = !req[gnt_id];
  assign w_rel_b = (MAX_HOLD != 0) && (r_hold == CW'(MAX_HOLD - 1));
  pc_4_2 u_pc (
    .I(w_rot),
    .Y(w_y),
    .W(w_w)
  );
  // FSM: pick a winner in IDLE, hold it in GRANT until release or timeout, then force a dead cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= 2'd0;
      r_hold  <= '0;
      gnt     <= '0;
      gnt_id  <= 2'd0;
      busy    <= 1'b0;
      expire  <= 1'b0;
    end else begin
      expire <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (w_w) begin
          gnt     <= N_REQ'(1) << w_win;
          gnt_id  <= w_win;
          busy    <= 1'b1;
          r_hold  <= '0;
          r_state <= ST_GRANT;
        end
      end else begin
        r_hold <= r_hold + 1'b1;
        if (w_rel_a || w_rel_b) begin
          gnt     <= '0;
          gnt_id  <= 2'd0;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
          r_ptr   <= ROUND_ROBIN != 0 ? gnt_id : 2'd0;
          expire  <= !w_rel_a;
        end
      end
    end
  end
endmodule
